// File: rtl/mor1kx_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO over a registered-read array.
// Optional misuse detection: define MOR1KX_SYNC_FIFO_ERR_EN to enable err_o.
module mor1kx_sync_fifo_fwft #(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_WIDTH:0]  count_o,
  output logic                  err_o
);

  localparam logic [DEPTH_WIDTH-1:0] PTR_ZERO   = {DEPTH_WIDTH{1'b0}};
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE    = DEPTH_WIDTH'(1'b1);
  localparam logic [DEPTH_WIDTH:0]   COUNT_ZERO = {(DEPTH_WIDTH+1){1'b0}};
  localparam logic [DEPTH_WIDTH:0]   COUNT_ONE  = (DEPTH_WIDTH+1)'(1'b1);
  localparam logic [DEPTH_WIDTH:0]   COUNT_FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0]  mem_r [0:(1<<DEPTH_WIDTH)-1];
  logic [DEPTH_WIDTH-1:0] wr_ptr_r;
  logic [DEPTH_WIDTH-1:0] rd_ptr_r;
  logic [DEPTH_WIDTH:0]   count_r;
  logic                   empty_r;
  logic                   full_r;
  logic [DATA_WIDTH-1:0]  dout_r;

  logic                   push_s;
  logic                   pop_s;
  logic [DEPTH_WIDTH-1:0] rd_ptr_nxt_s;
  logic [DEPTH_WIDTH:0]   count_nxt_s;
  logic                   rd_en_s;
  logic                   fwd_s;

  // Accept/reject decisions, speculative read address and next occupancy.
  always_comb begin
    push_s       = wr_i & ~full_r;
    pop_s        = rd_i & ~empty_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + COUNT_ONE;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - COUNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
    // Head output is refreshed only while entries remain, so it holds when empty.
    rd_en_s = (count_nxt_s != COUNT_ZERO);
    // The slot becoming head is written this very cycle: bypass the array.
    fwd_s   = push_s && (wr_ptr_r == rd_ptr_nxt_s);
  end

  // Storage array write port; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din_i;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= COUNT_ZERO;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      empty_r  <= (count_nxt_s == COUNT_ZERO);
      full_r   <= (count_nxt_s == COUNT_FULL);
    end
  end

  // Registered array read port presenting the head entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_en_s) begin
      if (fwd_s) begin
        dout_r <= din_i;
      end else begin
        dout_r <= mem_r[rd_ptr_nxt_s];
      end
    end
  end

`ifdef MOR1KX_SYNC_FIFO_ERR_EN
  logic err_r;

  // Sticky flag for rejected pushes and pops; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((wr_i && full_r) || (rd_i && empty_r)) begin
      err_r <= 1'b1;
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

  assign dout_o  = dout_r;
  assign empty_o = empty_r;
  assign full_o  = full_r;
  assign count_o = count_r;

endmodule

// File: tb/tb_mor1kx_sync_fifo_fwft.sv
// Directed bench for mor1kx_sync_fifo_fwft: vector table plus queue-model sequences.
module tb_mor1kx_sync_fifo_fwft;

`ifdef MOR1KX_SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_i = 1'b0;
  logic        rd_i = 1'b0;
  logic [31:0] din_i = 32'h0;
  logic [31:0] dout_o;
  logic        empty_o;
  logic        full_o;
  logic [4:0]  count_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] q[$];
  bit          m_err = 1'b0;

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [31:0] din;
    logic [4:0]  cnt;
    logic        emp;
    logic        ful;
    logic        err;
    logic        chk_dout;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[11];

  mor1kx_sync_fifo_fwft #(.DEPTH_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .wr_i(wr_i), .din_i(din_i), .rd_i(rd_i),
    .dout_o(dout_o), .empty_o(empty_o), .full_o(full_o),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the reference queue, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic w, input logic d, input logic [31:0] v);
    int sz;
    rst = r; wr_i = w; rd_i = d; din_i = v;
    sz = q.size();
    if (r) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      if (ERR_EN && ((w && sz == 16) || (d && sz == 0))) m_err = 1'b1;
      if (d && sz > 0) void'(q.pop_front());
      if (w && sz < 16) q.push_back(v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string name);
    cmp({name, ".count"}, {27'h0, count_o}, q.size());
    cmp({name, ".empty"}, {31'h0, empty_o}, {31'h0, q.size() == 0});
    cmp({name, ".full"},  {31'h0, full_o},  {31'h0, q.size() == 16});
    cmp({name, ".err"},   {31'h0, err_o},   {31'h0, m_err});
    if (q.size() > 0) cmp({name, ".dout"}, dout_o, q[0]);
  endtask

  initial begin
    //          rst   wr    rd    din           cnt   emp   ful   err   chk   dout
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'hA5A50001, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A50001};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0,        5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h33,       5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,        5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h11,       5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h22,       5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h55,       5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,        5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,        5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

    #2;
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      cmp($sformatf("vec%0d.count", i), {27'h0, count_o}, {27'h0, vecs[i].cnt});
      cmp($sformatf("vec%0d.empty", i), {31'h0, empty_o}, {31'h0, vecs[i].emp});
      cmp($sformatf("vec%0d.full", i),  {31'h0, full_o},  {31'h0, vecs[i].ful});
      cmp($sformatf("vec%0d.err", i),   {31'h0, err_o},   {31'h0, vecs[i].err & ERR_EN});
      if (vecs[i].chk_dout) cmp($sformatf("vec%0d.dout", i), dout_o, vecs[i].dout);
    end

    // Fill to capacity, then drain one per cycle.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, i);
      check_model($sformatf("fill%0d", i));
    end
    cmp("full_flag", {31'h0, full_o}, 32'h1);
    cmp("full_count", {27'h0, count_o}, 32'd16);
    for (int i = 0; i < 16; i++) begin
      cmp($sformatf("drain_head%0d", i), dout_o, i);
      step(1'b0, 1'b0, 1'b1, 32'h0);
      check_model($sformatf("drain%0d", i));
    end

    // Forwarding at count 1, then 40 cycles of push+pop across pointer wrap.
    step(1'b0, 1'b1, 1'b0, 32'h11);
    step(1'b0, 1'b1, 1'b1, 32'h22);
    cmp("fwd_count", {27'h0, count_o}, 32'd1);
    cmp("fwd_dout", dout_o, 32'h22);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'h1000 + i);
      check_model($sformatf("stream1_%0d", i));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h2000 + i);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'h3000 + i);
      check_model($sformatf("stream7_%0d", i));
    end

    // Push+pop while full: pop taken, push dropped.
    while (q.size() < 16) step(1'b0, 1'b1, 1'b0, 32'h4000 + q.size());
    step(1'b0, 1'b1, 1'b1, 32'hDEAD);
    cmp("full_wrrd_count", {27'h0, count_o}, 32'd15);
    cmp("full_wrrd_err", {31'h0, err_o}, {31'h0, ERR_EN});
    check_model("full_wrrd");
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0);
      check_model($sformatf("post_full%0d", i));
    end
    cmp("err_sticky", {31'h0, err_o}, {31'h0, ERR_EN});

    // Reset with 9 entries held.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 32'h5000 + i);
    cmp("pre_rst_count", {27'h0, count_o}, 32'd9);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    cmp("rst9_count", {27'h0, count_o}, 32'd0);
    cmp("rst9_empty", {31'h0, empty_o}, 32'h1);
    cmp("rst9_err", {31'h0, err_o}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h44);
    cmp("rst9_push_dout", dout_o, 32'h44);
    check_model("rst9_push");
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check_model("rst9_pop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mor1kx_sync_fifo_fwft.md
# mor1kx_sync_fifo_fwft

Single-clock, first-word-fall-through FIFO built on a registered-read storage array; it is the block that both writes and reads the array, driving write address/enable from the push side and read address/enable from the pop side. It sits between a producer and a consumer within one clock domain, for example the store buffer and the data bus interface. The head entry is presented on `dout_o` whenever the FIFO is non-empty, with no read-request latency.

## Interface
- `DEPTH_WIDTH`, 4, log2 of capacity; capacity = 2^DEPTH_WIDTH entries
- `DATA_WIDTH`, 32, entry width in bits
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous and active-high
- `wr_i`  in  1  push request
- `din_i`  in  DATA_WIDTH  push data
- `rd_i`  in  1  pop request (acknowledges the current head)
- `dout_o`  out  DATA_WIDTH  head entry; valid when `empty_o`=0
- `empty_o`  out  1  no entries held
- `full_o`  out  1  2^DEPTH_WIDTH entries held
- `count_o`  out  DEPTH_WIDTH+1  occupancy, 0..2^DEPTH_WIDTH
- `err_o`  out  1  sticky misuse flag (see Configuration)

## Operation
- Storage: 2^DEPTH_WIDTH x DATA_WIDTH array with registered read port. Write pointer and read pointer are each DEPTH_WIDTH bits and wrap modulo 2^DEPTH_WIDTH with no special case.
- Push accepted iff `wr_i`=1 and `full_o`=0. A push while full is dropped, even if `rd_i`=1 in the same cycle.
- Pop accepted iff `rd_i`=1 and `empty_o`=0. A pop while empty is ignored, even if `wr_i`=1 in the same cycle.
- `count_o` next value: +1 on push only, -1 on pop only, unchanged on both or neither. `empty_o` = (count==0). `full_o` = (count==2^DEPTH_WIDTH). Both are registered, not decoded from inputs.
- FWFT: whenever `empty_o`=0, `dout_o` equals the oldest accepted, unpopped entry.
  - After a pop, the next entry must appear on the following cycle. The read pointer is advanced speculatively so the array read is issued in the pop cycle.
  - When the location being read is written in the same cycle, the written data must be forwarded. This covers push into empty, and push into count=1 with a simultaneous pop.
- `dout_o` is don't-care while `empty_o`=1. It holds its last value and is not cleared.
- Reset values: pointers 0, `count_o`=0, `empty_o`=1, `full_o`=0, `err_o`=0, `dout_o`=0. Array contents are not reset.
- Reset mid-operation discards all entries. The first push after reset lands at pointer 0.

## Timing
- Push-to-visible latency is 1 cycle. Push at edge N into an empty FIFO gives `empty_o`=0 and `dout_o`=din after edge N.
- Pop-to-next-head latency is 1 cycle. No bubble cycles under continuous push+pop at any occupancy 1..capacity-1.
- Flags and count update on the same edge that accepts the push/pop.
- Sustained throughput: one push and one pop per cycle.
- No combinational path from `wr_i`/`rd_i`/`din_i` to any output.

## Configuration
- `MOR1KX_SYNC_FIFO_ERR_EN` defined:
  - `err_o` sets on the edge after a rejected push (`wr_i` while full, with or without `rd_i`).
  - `err_o` sets on the edge after a rejected pop (`rd_i` while empty).
  - `err_o` then stays 1 until `rst`.
- Not defined: `err_o` is tied to 0 and no detection logic is synthesised. FIFO behaviour is otherwise identical.

## Test plan
- Reset, then push 0xA5A5_0001 once -> next cycle `empty_o`=0, `count_o`=1, `dout_o`=0xA5A5_0001. Then pop -> next cycle `empty_o`=1, `count_o`=0.
- Fill (DEPTH_WIDTH=4) with pushes 0..15 -> `full_o`=1, `count_o`=16. Pop all -> `dout_o` sequence 0..15, one per cycle, no stalls.
- At count=1 (head 0x11), push 0x22 with a simultaneous pop -> next cycle `count_o`=1, `dout_o`=0x22 (forwarding). Continuous push+pop for 40 cycles across pointer wrap -> output matches the input order exactly.
- When full, assert `wr_i`+`rd_i` with din 0xDEAD -> pop accepted, push dropped, `count_o`=15. With ERR_EN, `err_o`=1 persists.
- When empty, assert `rd_i`+`wr_i` with din 0x33 -> `count_o`=1, `dout_o`=0x33. With ERR_EN, `err_o`=1; without it, `err_o` stays 0.
- Reset asserted at count=9 -> next cycle `count_o`=0, `empty_o`=1, `err_o`=0. Push 0x44 -> `dout_o`=0x44.
